// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   state_t : arbiter bus state (IDLE / ACCESS / TURN)
//   owner_t : which requester owns the access on the bus
package mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Eligibility check, priority pick and core starvation counter.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   state, cur_wr  : bus state and write flag of the access on the bus
//   core_req/_wr   : core request and its direction
//   dbg_req/_wr    : debug request and its direction
//   winner         : requester that wins this cycle (valid when |gnt)
//   gnt            : one-hot grant vector, [0]=core, [1]=debug
//   starve_cnt     : consecutive cycles the eligible core lost to debug
module mem_arb_prio
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  state_t     state,
  input  logic       cur_wr,
  input  logic       core_req,
  input  logic       core_wr,
  input  logic       dbg_req,
  input  logic       dbg_wr,
  output owner_t     winner,
  output logic [1:0] gnt,
  output logic [3:0] starve_cnt
);

  logic core_elig;
  logic dbg_elig;
  logic core_starved;

  // A read may not be issued while a write is on the bus: the next cycle
  // has to be a turnaround. Writes may always follow directly.
  always_comb begin
    core_elig    = core_req && ((state != ACCESS) || core_wr || !cur_wr);
    dbg_elig     = dbg_req  && ((state != ACCESS) || dbg_wr  || !cur_wr);
    core_starved = (starve_cnt == 4'(STARVE_MAX));
    gnt          = 2'b00;
    winner       = OWN_DBG;
    if (core_elig && core_starved) begin
      gnt    = 2'b01;
      winner = OWN_CORE;
    end else if (dbg_elig) begin
      gnt    = 2'b10;
      winner = OWN_DBG;
    end else if (core_elig) begin
      gnt    = 2'b01;
      winner = OWN_CORE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= 4'd0;
    end else if (gnt[0]) begin
      starve_cnt <= 4'd0;
    end else if (core_elig && gnt[1] && !core_starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single SRAM port: CPU core (port C) and the
// JTAG/debug engine (port D). One registered SRAM command per cycle, with a
// turnaround cycle inserted when a read follows a write.
//
// Handshake: each port presents Req (valid) with Wr/Addr/Data held stable;
// Gnt (ready, combinational) marks the cycle the command is accepted. A
// requester may drop Req before Gnt to withdraw the command. Done pulses one
// cycle after the SRAM access cycle, on the owner's port only; o_rdData
// carries the read result from that cycle until the next read completes.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_core*/o_core*               core command port and grant/done
//   i_dbg*/o_dbg*                 debug command port and grant/done
//   o_rdData                      read data for the port pulsing done
//   o_memEn/Wr/Addr/WrData        registered SRAM command
//   i_memRdData                   SRAM read data (end of ACCESS cycle)
//   o_fsmState, o_starveCnt       debug observation of state and counter
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_coreReq,
  input  logic              i_coreWr,
  input  logic [ADDR_W-1:0] i_coreAddr,
  input  logic [DATA_W-1:0] i_coreData,
  output logic              o_coreGnt,
  output logic              o_coreDone,
  input  logic              i_dbgReq,
  input  logic              i_dbgWr,
  input  logic [ADDR_W-1:0] i_dbgAddr,
  input  logic [DATA_W-1:0] i_dbgData,
  output logic              o_dbgGnt,
  output logic              o_dbgDone,
  output logic [DATA_W-1:0] o_rdData,
  output logic              o_memEn,
  output logic              o_memWr,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWrData,
  input  logic [DATA_W-1:0] i_memRdData,
  output logic [1:0]        o_fsmState,
  output logic [3:0]        o_starveCnt
);

  state_t            state_q, state_d;
  owner_t            owner_q;
  owner_t            winner;
  logic [1:0]        gnt_raw;
  logic [1:0]        grant;
  logic              read_pending;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              mem_en_q;
  // mem_wr_q doubles as the write flag of the access currently on the bus.
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              core_done_q, dbg_done_q;
  logic [DATA_W-1:0] rd_data_q;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .state      (state_q),
    .cur_wr     (mem_wr_q),
    .core_req   (i_coreReq),
    .core_wr    (i_coreWr),
    .dbg_req    (i_dbgReq),
    .dbg_wr     (i_dbgWr),
    .winner     (winner),
    .gnt        (gnt_raw),
    .starve_cnt (o_starveCnt)
  );

  // Grants are combinational, so reset has to mask them directly to make
  // every output read zero while reset is held.
  assign grant        = gnt_raw & {2{~i_rst}};
  assign read_pending = (i_coreReq && !i_coreWr) || (i_dbgReq && !i_dbgWr);

  always_comb begin
    win_wr   = i_dbgWr;
    win_addr = i_dbgAddr;
    win_data = i_dbgData;
    state_d  = IDLE;
    if (winner == OWN_CORE) begin
      win_wr   = i_coreWr;
      win_addr = i_coreAddr;
      win_data = i_coreData;
    end
    if (|grant) begin
      state_d = ACCESS;
    end else if ((state_q == ACCESS) && mem_wr_q && read_pending) begin
      state_d = TURN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CORE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_done_q <= 1'b0;
      dbg_done_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q  <= state_d;
      mem_en_q <= (state_d == ACCESS);
      // Command fields only load on acceptance; they hold otherwise.
      if (|grant) begin
        owner_q     <= winner;
        mem_wr_q    <= win_wr;
        mem_addr_q  <= win_addr;
        mem_wdata_q <= win_data;
      end
      core_done_q <= (state_q == ACCESS) && (owner_q == OWN_CORE);
      dbg_done_q  <= (state_q == ACCESS) && (owner_q == OWN_DBG);
      if ((state_q == ACCESS) && !mem_wr_q) begin
        rd_data_q <= i_memRdData;
      end
    end
  end

  assign o_coreGnt   = grant[0];
  assign o_dbgGnt    = grant[1];
  assign o_coreDone  = core_done_q;
  assign o_dbgDone   = dbg_done_q;
  assign o_rdData    = rd_data_q;
  assign o_memEn     = mem_en_q;
  assign o_memWr     = mem_wr_q;
  assign o_memAddr   = mem_addr_q;
  assign o_memWrData = mem_wdata_q;
  assign o_fsmState  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 4;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst;
  logic          i_coreReq, i_coreWr, i_dbgReq, i_dbgWr;
  logic [AW-1:0] i_coreAddr, i_dbgAddr;
  logic [DW-1:0] i_coreData, i_dbgData, i_memRdData;
  logic          o_coreGnt, o_coreDone, o_dbgGnt, o_dbgDone;
  logic          o_memEn, o_memWr;
  logic [AW-1:0] o_memAddr;
  logic [DW-1:0] o_memWrData, o_rdData;
  logic [1:0]    o_fsmState;
  logic [3:0]    o_starveCnt;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_coreReq   (i_coreReq),
    .i_coreWr    (i_coreWr),
    .i_coreAddr  (i_coreAddr),
    .i_coreData  (i_coreData),
    .o_coreGnt   (o_coreGnt),
    .o_coreDone  (o_coreDone),
    .i_dbgReq    (i_dbgReq),
    .i_dbgWr     (i_dbgWr),
    .i_dbgAddr   (i_dbgAddr),
    .i_dbgData   (i_dbgData),
    .o_dbgGnt    (o_dbgGnt),
    .o_dbgDone   (o_dbgDone),
    .o_rdData    (o_rdData),
    .o_memEn     (o_memEn),
    .o_memWr     (o_memWr),
    .o_memAddr   (o_memAddr),
    .o_memWrData (o_memWrData),
    .i_memRdData (i_memRdData),
    .o_fsmState  (o_fsmState),
    .o_starveCnt (o_starveCnt)
  );

  // ---------------- scoreboard state ----------------
  int n_asserts = 0;
  int n_fail    = 0;

  logic [DW-1:0] sram  [0:65535];  // SRAM contents as driven by the DUT
  logic [DW-1:0] mem_m [0:65535];  // SRAM contents as the model expects
  logic [DW-1:0] exp_q [$];        // read data expected at upcoming dones

  // Transaction-level model: a command accepted in cycle N is on the bus in
  // N+1 and completes in N+2. A read is blocked exactly when the previous
  // cycle accepted a write.
  bit            g1, g1_wr, g2, g2_wr;
  int            g1_own, g2_own;   // 0 = core, 1 = debug
  logic [AW-1:0] g1_addr;
  logic [DW-1:0] g1_data;
  int            starve;
  logic [DW-1:0] rd_held;
  int            win;              // 0 = none, 1 = core, 2 = debug

  bit            obs_cg, obs_dg, obs_en, obs_cd, obs_dd;
  logic [DW-1:0] obs_rd;

  function automatic logic [DW-1:0] init_word(input int a);
    return 16'(a) ^ 16'hC3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_core(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_coreReq = r; i_coreWr = w; i_coreAddr = a; i_coreData = d;
  endtask

  task automatic set_dbg(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_dbgReq = r; i_dbgWr = w; i_dbgAddr = a; i_dbgData = d;
  endtask

  task automatic model_reset();
    g1 = 0; g2 = 0; g1_wr = 0; g2_wr = 0; g1_own = 0; g2_own = 0;
    starve = 0; rd_held = '0; exp_q.delete();
  endtask

  // One clock cycle: entered just after a rising edge with inputs already
  // driven; checks at the falling edge, returns just after the next rising edge.
  task automatic cyc();
    bit            core_el, dbg_el, sram_we;
    logic [AW-1:0] we_a;
    logic [DW-1:0] we_d;
    @(negedge i_clk);
    i_memRdData = sram[o_memAddr];
    core_el = i_coreReq && !(g1 && g1_wr && !i_coreWr);
    dbg_el  = i_dbgReq  && !(g1 && g1_wr && !i_dbgWr);
    if (core_el && starve == SM) win = 1;
    else if (dbg_el)             win = 2;
    else if (core_el)            win = 1;
    else                         win = 0;
    chk("core_gnt", 32'(o_coreGnt), 32'(win == 1));
    chk("dbg_gnt",  32'(o_dbgGnt),  32'(win == 2));
    chk("mem_en",   32'(o_memEn),   32'(g1));
    if (g1) begin
      chk("mem_wr",   32'(o_memWr),   32'(g1_wr));
      chk("mem_addr", 32'(o_memAddr), 32'(g1_addr));
      if (g1_wr) chk("mem_wdata", 32'(o_memWrData), 32'(g1_data));
      else       exp_q.push_back(mem_m[g1_addr]);
    end
    chk("core_done", 32'(o_coreDone), 32'(g2 && g2_own == 0));
    chk("dbg_done",  32'(o_dbgDone),  32'(g2 && g2_own == 1));
    if (g2 && !g2_wr && exp_q.size() > 0) rd_held = exp_q.pop_front();
    chk("rd_data",    32'(o_rdData),    32'(rd_held));
    chk("starve_cnt", 32'(o_starveCnt), 32'(starve));
    obs_cg = o_coreGnt; obs_dg = o_dbgGnt; obs_en = o_memEn;
    obs_cd = o_coreDone; obs_dd = o_dbgDone; obs_rd = o_rdData;
    sram_we = o_memEn && o_memWr; we_a = o_memAddr; we_d = o_memWrData;
    @(posedge i_clk);
    #1;
    if (sram_we) sram[we_a] = we_d;
    if (g1 && g1_wr) mem_m[g1_addr] = g1_data;
    g2 = g1; g2_wr = g1_wr; g2_own = g1_own;
    g1 = (win != 0);
    if (win == 1) begin
      g1_own = 0; g1_wr = i_coreWr; g1_addr = i_coreAddr; g1_data = i_coreData;
      starve = 0;
    end else if (win == 2) begin
      g1_own = 1; g1_wr = i_dbgWr; g1_addr = i_dbgAddr; g1_data = i_dbgData;
      if (core_el) starve = (starve + 1 > SM) ? SM : starve + 1;
    end
  endtask

  // ---------------- directed steps, then random traffic ----------------
  bit            c_act, c_wr, d_act, d_wr;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_data, d_data;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      sram[a]  = init_word(a);
      mem_m[a] = init_word(a);
    end
    sram[16'h1234]  = 16'hBEEF;
    mem_m[16'h1234] = 16'hBEEF;
    i_rst = 1'b1;
    i_memRdData = '0;
    set_core(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0);
    model_reset();
    #1;
    chk("rst_mem_en",   32'(o_memEn),    32'd0);
    chk("rst_state",    32'(o_fsmState), 32'd0);
    chk("rst_rd_data",  32'(o_rdData),   32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Reset asserted mid-ACCESS, entirely between clock edges.
    set_core(1, 0, 16'h0010, '0);
    cyc();
    #1;
    i_rst = 1'b1;
    #1;
    chk("t1_async_mem_en", 32'(o_memEn),    32'd0);
    chk("t1_async_gnt",    32'(o_coreGnt),  32'd0);
    chk("t1_async_done",   32'(o_coreDone), 32'd0);
    chk("t1_async_state",  32'(o_fsmState), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    set_core(0, 0, '0, '0);
    @(posedge i_clk);
    #1;
    model_reset();
    cyc();
    chk("t1_no_done", 32'(obs_cd), 32'd0);
    set_core(1, 0, 16'h0010, '0);
    cyc();
    chk("t1_regrant", 32'(obs_cg), 32'd1);
    set_core(0, 0, '0, '0);
    cyc();
    cyc();

    // Single core read with fixed latency.
    set_core(1, 0, 16'h1234, '0);
    cyc();
    chk("t2_gnt", 32'(obs_cg), 32'd1);
    set_core(0, 0, '0, '0);
    cyc();
    chk("t2_mem_en", 32'(obs_en), 32'd1);
    cyc();
    chk("t2_done", 32'(obs_cd), 32'd1);
    chk("t2_rd",   32'(obs_rd), 32'hBEEF);

    // Write then read of the same word: one turnaround cycle.
    set_core(1, 1, 16'h0005, 16'hA5A5);
    cyc();
    chk("t3_wr_gnt", 32'(obs_cg), 32'd1);
    set_core(1, 0, 16'h0005, '0);
    cyc();
    chk("t3_rd_held", 32'(obs_cg), 32'd0);
    cyc();
    chk("t3_turn_en", 32'(obs_en), 32'd0);
    chk("t3_rd_gnt",  32'(obs_cg), 32'd1);
    set_core(0, 0, '0, '0);
    cyc();
    cyc();
    chk("t3_done", 32'(obs_cd), 32'd1);
    chk("t3_rd",   32'(obs_rd), 32'hA5A5);

    // Continuous contention on writes: 4 debug grants then 1 core grant.
    for (int i = 0; i < 10; i++) begin
      set_dbg(1, 1, 16'(16'h0200 + i), 16'(i));
      set_core(1, 1, 16'h0100, 16'hC0DE);
      cyc();
      chk("t4_dbg_gnt",  32'(obs_dg), 32'((i % 5) != 4));
      chk("t4_core_gnt", 32'(obs_cg), 32'((i % 5) == 4));
    end
    set_core(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0);
    cyc();
    cyc();

    // Debug write beats a simultaneous core read; the read waits out TURN.
    set_dbg(1, 1, 16'h0300, 16'h1111);
    set_core(1, 0, 16'h0300, '0);
    cyc();
    chk("t5_dbg_gnt",  32'(obs_dg), 32'd1);
    chk("t5_core_gnt", 32'(obs_cg), 32'd0);
    set_dbg(0, 0, '0, '0);
    cyc();
    chk("t5_core_wait", 32'(obs_cg), 32'd0);
    cyc();
    chk("t5_turn_en",   32'(obs_en), 32'd0);
    chk("t5_core_gnt2", 32'(obs_cg), 32'd1);
    set_core(0, 0, '0, '0);
    cyc();
    cyc();
    chk("t5_done", 32'(obs_cd), 32'd1);
    chk("t5_rd",   32'(obs_rd), 32'h1111);

    // Back-to-back core reads of 0..3.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_core(1, 0, 16'(k), '0);
      else       set_core(0, 0, '0, '0);
      cyc();
      chk("t6_gnt",    32'(obs_cg), 32'(k < 4));
      chk("t6_mem_en", 32'(obs_en), 32'(k >= 1 && k <= 4));
      chk("t6_done",   32'(obs_cd), 32'(k >= 2));
      if (k >= 2) chk("t6_rd", 32'(obs_rd), 32'(init_word(k - 2)));
    end

    // Random traffic; requesters hold commands until granted or withdrawn.
    c_act = 0; d_act = 0;
    c_wr = 0; d_wr = 0; c_addr = '0; d_addr = '0; c_data = '0; d_data = '0;
    for (int n = 0; n < 800; n++) begin
      if (!c_act && $urandom_range(0, 99) < 60) begin
        c_act = 1; c_wr = 1'($urandom_range(0, 1));
        c_addr = 16'($urandom_range(0, 7)); c_data = 16'($urandom);
      end else if (c_act && $urandom_range(0, 99) < 4) begin
        c_act = 0;
      end
      if (!d_act && $urandom_range(0, 99) < 80) begin
        d_act = 1; d_wr = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 7)); d_data = 16'($urandom);
      end else if (d_act && $urandom_range(0, 99) < 4) begin
        d_act = 0;
      end
      set_core(c_act, c_wr, c_addr, c_data);
      set_dbg(d_act, d_wr, d_addr, d_data);
      cyc();
      if (win == 1) c_act = 0;
      if (win == 2) d_act = 0;
    end
    set_core(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0);
    cyc();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single SRAM port between two requesters: the CPU core (port C) and the JTAG/debug engine (port D).
- Issues one registered SRAM command per cycle and returns read data and completion pulses to the owning requester.
- Enforces a bus-turnaround cycle when a read follows a write.
- Sits between the core/debug logic and the SRAM pin/boundary-scan wrapper inside the processor top.

Parameters:
ADDR_W, 16, SRAM word address width
DATA_W, 16, SRAM data width
STARVE_MAX, 4, consecutive denied core-request cycles before the core overrides debug priority (1..15)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_coreReq  in  1  core command valid; held until o_coreGnt
i_coreWr  in  1  core command is a write
i_coreAddr  in  ADDR_W  core address
i_coreData  in  DATA_W  core write data
o_coreGnt  out  1  combinational; core command accepted this cycle
o_coreDone  out  1  one-cycle pulse when the core access completes
i_dbgReq, i_dbgWr, i_dbgAddr, i_dbgData, o_dbgGnt, o_dbgDone  (same directions, widths and semantics as the core port)
o_rdData  out  DATA_W  read data for the port currently pulsing done
o_memEn  out  1  SRAM access enable (registered)
o_memWr  out  1  SRAM write (registered)
o_memAddr  out  ADDR_W  SRAM address (registered)
o_memWrData  out  DATA_W  SRAM write data (registered)
i_memRdData  in  DATA_W  SRAM read data; valid at the end of an ACCESS cycle

Behaviour:
- Reset: asynchronous; all outputs go to 0 immediately, state becomes IDLE, starvation counter is 0. An in-flight access is dropped and no done pulse is produced.
- States:
  - IDLE: memEn=0.
  - ACCESS: memEn=1, exactly one command on the bus.
  - TURN: memEn=0, entered only after a write.
- Grant eligibility:
  - In IDLE or TURN, any request can be granted.
  - In ACCESS, a write request can be granted. A read request can be granted only if the current access is a read.
- Winner selection: debug has priority. If starve_cnt == STARVE_MAX and the core is eligible, the core wins instead. Only the winner's Gnt is asserted, at most one per cycle.
- Accept edge: on the rising edge that ends a grant cycle:
  - The winner's Wr/Addr/Data are registered onto the mem outputs.
  - The owner ID and the write flag are registered.
  - State goes to ACCESS.
- Leaving ACCESS with no grant:
  - If the access was a write and a read is pending, go to TURN.
  - Otherwise go to IDLE.
- Leaving TURN: to ACCESS if a grant occurs, else to IDLE.
- Write data: in non-ACCESS states, o_memWr, o_memAddr and o_memWrData hold their last values; only memEn drops.
- Latency: Req and Gnt in cycle N; memEn=1 in cycle N+1; Done pulse in cycle N+2. For reads, o_rdData = i_memRdData sampled at the end of N+1, valid in N+2 and held until the next read completes.
- Throughput:
  - Back-to-back accesses give one per cycle.
  - Write followed by read inserts exactly one TURN cycle.
  - Read followed by write needs no gap.
- Done: pulses for both reads and writes, on the owner's Done only. Core Done and debug Done are never high together.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) in each cycle where the core is requesting and eligible and debug wins.
  - Clears when the core is granted.
  - Holds otherwise.
- Simultaneous requests:
  - Both requesting and eligible: debug wins unless the core is starved.
  - Core starved but ineligible (read during write ACCESS): debug's eligible request still proceeds. If neither is eligible, there is no grant.
- Requester protocol: Req with Wr/Addr/Data must stay stable until Gnt. Dropping Req before Gnt withdraws the command. This is legal and has no side effects.

Decomposition:
- Shared package (mem_pkg):
  - state enum {IDLE, ACCESS, TURN}.
  - owner enum {OWN_CORE, OWN_DBG}.
  - Default ADDR_W and DATA_W constants.
- Sub-module: mem_arb_prio, the combinational eligibility and priority pick plus the starvation counter. Outputs are the winner, the grant vector and the counter state.

Test Plan:
1. Reset pulse mid-ACCESS (core read, addr 0x0010) -> memEn, Done and Gnt go to 0 asynchronously; no done after release; first new request is granted normally.
2. Core read 0x1234 alone, SRAM returns 0xBEEF -> coreGnt in cycle N, memEn=1/memWr=0/addr=0x1234 in N+1, coreDone=1 and rdData=0xBEEF in N+2.
3. Core write 0x0005←0xA5A5 then read 0x0005 requested immediately -> ACCESS(write), TURN (memEn=0), ACCESS(read); read Done arrives 4 cycles after the write grant.
4. Debug and core both requesting writes continuously, STARVE_MAX=4 -> debug granted 4 cycles, core granted on the 5th, counter cleared; the pattern repeats 4:1.
5. Debug writes then core read in the same cycle as a debug write -> debug granted, core held; TURN inserted before the core read is granted.
6. Back-to-back core reads 0x0000..0x0003 -> memEn held high 4 cycles, 4 consecutive coreDone pulses, rdData tracks each address.
